// File: rtl/operand_capture_if.sv
// Operand-entry bus between the board I/O side (switches, enter button, ALU ready)
// and operand_capture. The block itself connects through the slave modport.
interface operand_capture_if #(
    parameter int N     = 4,
    parameter int N_OPS = 2,
    parameter int OUT_W = N + 2,
    parameter int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1
);
    logic                   clear;
    logic                   enter;
    logic                   signed_mode;
    logic [N-1:0]           switch_input;
    logic [N_OPS*OUT_W-1:0] operands;
    logic [IDX_W-1:0]       op_index;
    logic                   operands_valid;
    logic                   operands_ready;

    modport master (
        output clear, enter, signed_mode, switch_input, operands_ready,
        input  operands, op_index, operands_valid
    );

    modport slave (
        input  clear, enter, signed_mode, switch_input, operands_ready,
        output operands, op_index, operands_valid
    );
endinterface

// File: rtl/operand_capture.sv
// Sequenced operand entry: synchronises the enter button, captures N_OPS extended
// switch values slot by slot, then offers the set to the ALU with valid/ready.
module operand_capture #(
    parameter int N     = 4,
    parameter int N_OPS = 2,
    parameter int OUT_W = N + 2,
    parameter int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
    input logic              clk,
    input logic              reset,
    operand_capture_if.slave bus
);
    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OPS - 1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [N_OPS-1:0][OUT_W-1:0]    ops_q, ops_d;
    logic                           s1_q, s2_q, s3_q;
    logic                           enter_pulse;
    logic                           capture;
    logic [OUT_W-1:0]               ext;

    // s3 remembers the previous s2 so a held button yields a single pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.enter;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign enter_pulse = s2_q & ~s3_q;
    assign capture     = (state_q == COLLECT) & enter_pulse & ~bus.clear;

    always_comb begin
        ext        = '0;
        ext[N-1:0] = bus.switch_input;
        if (bus.signed_mode) begin
            for (int b = N; b < OUT_W; b++) ext[b] = bus.switch_input[N-1];
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ops_q   <= ops_d;
        end
    end

    // next state: clear outranks both the handshake and a capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ops_d   = ops_q;
        if (bus.clear) begin
            state_d = COLLECT;
            idx_d   = '0;
            ops_d   = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (enter_pulse) begin
                        for (int k = 0; k < N_OPS; k++) begin
                            if (idx_q == IDX_W'(k)) ops_d[k] = ext;
                        end
                        if (idx_q == LAST) state_d = FULL;
                        else               idx_d   = idx_q + IDX_W'(1);
                    end
                end
                FULL: begin
                    if (bus.operands_ready) begin
                        state_d = COLLECT;
                        idx_d   = '0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // outputs come straight from registers
    always_comb begin
        bus.operands_valid = (state_q == FULL);
        bus.op_index       = idx_q;
        bus.operands       = ops_q;
    end

endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture: three configurations driven in lockstep and compared
// every cycle against an event-level model of the entry sequence.
module tb_operand_capture;
    logic       clk = 1'b0;
    logic       reset;
    logic       en, sm, rdy, clr;
    logic [7:0] sw;
    logic       rst_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    operand_capture_if #(.N(4), .N_OPS(2), .OUT_W(6)) if0 ();
    operand_capture_if #(.N(8), .N_OPS(3), .OUT_W(8)) if1 ();
    operand_capture_if #(.N(4), .N_OPS(1), .OUT_W(6)) if2 ();

    assign if0.clear = clr; assign if0.enter = en; assign if0.signed_mode = sm;
    assign if0.switch_input = sw[3:0]; assign if0.operands_ready = rdy;
    assign if1.clear = clr; assign if1.enter = en; assign if1.signed_mode = sm;
    assign if1.switch_input = sw; assign if1.operands_ready = rdy;
    assign if2.clear = clr; assign if2.enter = en; assign if2.signed_mode = sm;
    assign if2.switch_input = sw[3:0]; assign if2.operands_ready = rdy;

    operand_capture #(.N(4), .N_OPS(2), .OUT_W(6)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    operand_capture #(.N(8), .N_OPS(3), .OUT_W(8)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    operand_capture #(.N(4), .N_OPS(1), .OUT_W(6)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    // ---------------- reference model ----------------
    int         CN   [3] = '{4, 8, 4};
    int         COPS [3] = '{2, 3, 1};
    int         COW  [3] = '{6, 8, 6};
    logic [7:0] m_slot [3][3];
    int         m_idx  [3];
    bit         m_full [3];
    bit         ehist[$];   // enter level seen at each edge since reset

    function automatic logic [7:0] extend(int n, int ow, logic [7:0] s, bit sgn);
        int v;
        v = int'(s) & ((1 << n) - 1);
        if (sgn && (((v >> (n - 1)) & 1) == 1)) v = v | ((1 << ow) - (1 << n));
        return v[7:0];
    endfunction

    task automatic model_reset();
        ehist = '{0, 0, 0};
        for (int d = 0; d < 3; d++) begin
            m_idx[d]  = 0;
            m_full[d] = 0;
            for (int k = 0; k < 3; k++) m_slot[d][k] = '0;
        end
    endtask

    // A press is recognised two edges after the edge that first sees it high.
    task automatic model_edge();
        bit pulse;
        if (!rst_v) begin
            model_reset();
            return;
        end
        ehist.push_back(en);
        if (ehist.size() > 4) void'(ehist.pop_front());
        pulse = ehist[ehist.size()-3] && !ehist[ehist.size()-4];
        for (int d = 0; d < 3; d++) begin
            if (clr) begin
                m_idx[d] = 0; m_full[d] = 0;
                for (int k = 0; k < 3; k++) m_slot[d][k] = '0;
            end else if (m_full[d]) begin
                if (rdy) begin m_full[d] = 0; m_idx[d] = 0; end
            end else if (pulse) begin
                m_slot[d][m_idx[d]] = extend(CN[d], COW[d], sw, sm);
                if (m_idx[d] == COPS[d] - 1) m_full[d] = 1;
                else                         m_idx[d]++;
            end
        end
    endtask

    function automatic logic [31:0] m_ops(int d);
        logic [31:0] e;
        e = '0;
        for (int k = 0; k < COPS[d]; k++) e = e | (32'(m_slot[d][k]) << (k * COW[d]));
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("ops0", 32'(if0.operands), m_ops(0));
        chk("idx0", 32'(if0.op_index), 32'(m_idx[0]));
        chk("vld0", 32'(if0.operands_valid), 32'(m_full[0]));
        chk("ops1", 32'(if1.operands), m_ops(1));
        chk("idx1", 32'(if1.op_index), 32'(m_idx[1]));
        chk("vld1", 32'(if1.operands_valid), 32'(m_full[1]));
        chk("ops2", 32'(if2.operands), m_ops(2));
        chk("idx2", 32'(if2.op_index), 32'(m_idx[2]));
        chk("vld2", 32'(if2.operands_valid), 32'(m_full[2]));
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input bit e, input logic [7:0] s, input bit m, input bit r, input bit c);
        @(negedge clk);
        reset = rst_v; en = e; sw = s; sm = m; rdy = r; clr = c;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic press(input logic [7:0] s, input bit m, input int hold);
        for (int i = 0; i < hold; i++) cyc(1, s, m, 0, 0);
        for (int i = 0; i < 3; i++)    cyc(0, s, m, 0, 0);
    endtask

    initial begin
        int  left;
        bit  lvl;
        rst_v = 0; reset = 0; en = 0; sm = 0; rdy = 0; clr = 0; sw = '0;
        model_reset();
        #1 check_all();
        chk("rst_ops0", 32'(if0.operands), 32'h0);
        rst_v = 1;

        // unsigned set, with explicit three-edge latency
        cyc(1, 8'h0B, 0, 0, 0);
        cyc(0, 8'h0B, 0, 0, 0);
        chk("lat_idx0_E2", 32'(if0.op_index), 32'd0);
        cyc(0, 8'h0B, 0, 0, 0);
        chk("lat_idx0_E3", 32'(if0.op_index), 32'd1);
        chk("u_slot0", 32'(if0.operands[5:0]), 32'b001011);
        cyc(0, 8'h0B, 0, 0, 0);
        press(8'h03, 0, 1);
        chk("u_set", 32'(if0.operands), 32'h0CB);
        chk("u_vld", 32'(if0.operands_valid), 32'd1);
        cyc(0, 8'h03, 0, 1, 0);
        chk("hs_vld", 32'(if0.operands_valid), 32'd0);
        chk("hs_keep", 32'(if0.operands), 32'h0CB);

        // signed set, mode changes between slots
        press(8'h0B, 1, 1);
        chk("s_slot0", 32'(if0.operands[5:0]), 32'b111011);
        press(8'h0B, 0, 1);
        chk("s_set", 32'(if0.operands), 32'h2FB);
        cyc(0, 8'h00, 0, 1, 0);

        // held button: one capture only
        press(8'h05, 0, 20);
        chk("held_idx0", 32'(if0.op_index), 32'd1);
        press(8'h06, 1, 2);
        press(8'h0F, 1, 1);   // ignored while full
        press(8'h0E, 0, 3);
        chk("full_hold", 32'(if0.operands), {20'h0, 6'b000110, 6'b000101});
        cyc(0, 8'h00, 0, 1, 0);

        // priority: clear + ready + enter pulse together while full
        press(8'h09, 0, 1);
        press(8'h0A, 0, 1);
        cyc(1, 8'h07, 0, 0, 0);
        cyc(1, 8'h07, 0, 0, 0);
        cyc(1, 8'h07, 0, 1, 1);
        chk("pri_ops0", 32'(if0.operands), 32'h0);
        chk("pri_vld0", 32'(if0.operands_valid), 32'd0);
        cyc(0, 8'h07, 0, 0, 0);
        cyc(0, 8'h07, 0, 0, 0);
        press(8'h0C, 0, 1);
        chk("pri_next", 32'(if0.operands[5:0]), 32'b001100);

        // asynchronous reset mid-capture, then release with enter held
        cyc(1, 8'h03, 0, 0, 0);
        cyc(1, 8'h03, 0, 0, 0);
        #3 reset = 0; rst_v = 0;
        #1 model_reset();
        check_all();
        chk("arst_idx0", 32'(if0.op_index), 32'd0);
        cyc(1, 8'h0D, 0, 0, 0);
        rst_v = 1;
        cyc(1, 8'h0D, 0, 0, 0);
        cyc(1, 8'h0D, 0, 0, 0);
        cyc(1, 8'h0D, 0, 0, 0);
        chk("rel_held", 32'(if0.operands[5:0]), 32'b001101);
        cyc(0, 8'h0D, 0, 0, 0);
        cyc(0, 8'h0D, 0, 0, 0);

        // randomized traffic
        left = 0; lvl = 0;
        for (int i = 0; i < 1500; i++) begin
            if (left == 0) begin
                lvl  = !lvl;
                left = lvl ? int'($urandom_range(1, 6)) : int'($urandom_range(2, 5));
            end
            left--;
            cyc(lvl, 8'($urandom), 1'($urandom), ($urandom % 4) == 0, ($urandom % 50) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
